// File: rtl/reg64_wr_arb.sv
// reg64_wr_arb: write-port controller for a shared 64-bit register made of
// four 16-bit lanes. Two requesters are arbitrated round-robin. A requester
// may take an exclusive lock, which is dropped on request, when idle, or on
// timeout. Each winner's masked lanes are merged into a shadow copy of the
// register, so back-to-back writes never read a stale register value.
module reg64_wr_arb #(
    parameter int LOCK_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [63:0] data0,
    input  logic [63:0] data1,
    input  logic [3:0]  mask0,
    input  logic [3:0]  mask1,
    output logic [63:0] reg_d,
    output logic        reg_en,
    output logic        gnt0,
    output logic        gnt1,
    output logic [1:0]  owner,
    output logic        lock_to
);

    localparam int LANES  = 4;
    localparam int LANE_W = 16;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Registered state. The shadow is the register's next contents and is
    // driven straight onto reg_d: it only changes on a committed write, which
    // is exactly when reg_d must carry the merged word.
    logic [63:0]      shadow_reg,  shadow_next;
    logic             reg_en_reg,  reg_en_next;
    logic [1:0]       gnt_reg,     gnt_next;
    logic [1:0]       owner_reg,   owner_next;
    logic             lock_to_reg, lock_to_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic             last_reg,    last_next;   // index of last-served requester

    // Requester inputs gathered into indexable form.
    logic [1:0]  req_vec;
    logic [1:0]  lock_vec;
    logic [63:0] data_arr [2];
    logic [3:0]  mask_arr [2];

    assign req_vec     = {req1, req0};
    assign lock_vec    = {lock1, lock0};
    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign mask_arr[0] = mask0;
    assign mask_arr[1] = mask1;

    // Lock bookkeeping derived from the current owner.
    logic locked;
    logic own_idx;
    logic own_req;
    logic own_lock;
    logic rel_idle;
    logic rel_timeout;
    logic lock_held;

    assign locked      = |owner_reg;
    assign own_idx     = owner_reg[1];
    assign own_req     = req_vec[own_idx];
    assign own_lock    = lock_vec[own_idx];
    // An owner that neither requests nor holds lock gives the lock up.
    assign rel_idle    = locked && !own_req && !own_lock;
    // An owner without a win at the last counted edge loses the lock.
    assign rel_timeout = locked && !own_req && (cnt_reg == CNT_LAST);
    // Lock still in force for this edge's arbitration; a releasing edge
    // arbitrates as if unlocked so the other side can win immediately.
    assign lock_held   = locked && !rel_idle && !rel_timeout;

    // Winner selection: owner-only while locked, otherwise round-robin.
    logic [1:0] win_vec;

    // Pick at most one winner from the sampled requests.
    always_comb begin
        win_vec = 2'b00;
        if (lock_held) begin
            win_vec = owner_reg & req_vec;
        end else begin
            unique case (req_vec)
                2'b01:   win_vec = 2'b01;
                2'b10:   win_vec = 2'b10;
                2'b11:   win_vec = last_reg ? 2'b01 : 2'b10;
                default: win_vec = 2'b00;
            endcase
        end
    end

    logic        win_any;
    logic        win_idx;
    logic        win_lock;
    logic [3:0]  win_mask;
    logic [63:0] win_data;
    logic [63:0] merged;

    assign win_any  = |win_vec;
    assign win_idx  = win_vec[1];
    assign win_lock = lock_vec[win_idx];
    assign win_mask = mask_arr[win_idx];
    assign win_data = data_arr[win_idx];

    // Lane merge: enabled lanes come from the winner, the rest from shadow.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged[gi*LANE_W +: LANE_W] = win_mask[gi]
                ? win_data[gi*LANE_W +: LANE_W]
                : shadow_reg[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // Next-state logic for the commit, the lock owner and the timeout counter.
    always_comb begin
        shadow_next  = shadow_reg;
        reg_en_next  = 1'b0;
        gnt_next     = win_vec;
        owner_next   = owner_reg;
        lock_to_next = rel_timeout;
        cnt_next     = cnt_reg;
        last_next    = last_reg;

        if (win_any) begin
            last_next = win_idx;
            if (|win_mask) begin
                shadow_next = merged;
                reg_en_next = 1'b1;
            end
        end

        // Releases first; a winner's own lock request then takes precedence,
        // so an owner re-winning with lock set simply renews it.
        if (rel_idle || rel_timeout) begin
            owner_next = 2'b00;
        end
        if (win_any) begin
            if (win_lock) begin
                owner_next = win_vec;
            end else if (owner_reg == win_vec) begin
                owner_next = 2'b00;
            end
        end

        // Counter measures edges since the owner's last win.
        if (owner_next == 2'b00 || win_any) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_reg  <= '0;
            reg_en_reg  <= 1'b0;
            gnt_reg     <= 2'b00;
            owner_reg   <= 2'b00;
            lock_to_reg <= 1'b0;
            cnt_reg     <= '0;
            last_reg    <= 1'b1;
        end else begin
            shadow_reg  <= shadow_next;
            reg_en_reg  <= reg_en_next;
            gnt_reg     <= gnt_next;
            owner_reg   <= owner_next;
            lock_to_reg <= lock_to_next;
            cnt_reg     <= cnt_next;
            last_reg    <= last_next;
        end
    end

    assign reg_d   = shadow_reg;
    assign reg_en  = reg_en_reg;
    assign gnt0    = gnt_reg[0];
    assign gnt1    = gnt_reg[1];
    assign owner   = owner_reg;
    assign lock_to = lock_to_reg;

    // Grants are mutually exclusive by construction of win_vec.
    gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst) !(gnt0 && gnt1));

endmodule

// File: tb/tb_reg64_wr_arb.sv
// Directed bench for reg64_wr_arb: reset, full and lane-merged writes,
// round-robin, lock with timeout, explicit unlock, and mid-cycle reset.
module tb_reg64_wr_arb;

    logic        clk;
    logic        rst;
    logic        req0, req1, lock0, lock1;
    logic [63:0] data0, data1;
    logic [3:0]  mask0, mask1;
    logic [63:0] reg_d;
    logic        reg_en, gnt0, gnt1, lock_to;
    logic [1:0]  owner;

    int checks_cnt = 0;
    int errors_cnt = 0;

    reg64_wr_arb #(.LOCK_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .data0(data0), .data1(data1), .mask0(mask0), .mask1(mask1),
        .reg_d(reg_d), .reg_en(reg_en), .gnt0(gnt0), .gnt1(gnt1),
        .owner(owner), .lock_to(lock_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one edge and sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        mask0 = 4'h0; mask1 = 4'h0;
        data0 = '0; data1 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            req0  = 1'($urandom); req1  = 1'($urandom);
            lock0 = 1'($urandom); lock1 = 1'($urandom);
            data0 = {$urandom, $urandom}; data1 = {$urandom, $urandom};
            mask0 = 4'($urandom); mask1 = 4'($urandom);
            step();
            check("rst_outs", {reg_d, reg_en, gnt1, gnt0, owner, lock_to}, '0);
        end
        check("rst_reg_d", reg_d, 64'h0);

        // First tie after release goes to requester 0.
        idle_inputs();
        req0 = 1'b1; req1 = 1'b1;
        rst = 1'b1;
        step();
        check("tie0_gnt", {gnt1, gnt0}, 2'b01);
        check("tie0_en", reg_en, 1'b0);

        // Single full write then back-to-back lane merge.
        idle_inputs();
        req0 = 1'b1; data0 = 64'h1111_2222_3333_4444; mask0 = 4'b1111;
        step();
        check("full_gnt", {gnt1, gnt0}, 2'b01);
        check("full_en", reg_en, 1'b1);
        check("full_d", reg_d, 64'h1111_2222_3333_4444);
        idle_inputs();
        req1 = 1'b1; data1 = 64'hAAAA_AAAA_AAAA_AAAA; mask1 = 4'b0101;
        step();
        check("merge_gnt", {gnt1, gnt0}, 2'b10);
        check("merge_en", reg_en, 1'b1);
        check("merge_d", reg_d, 64'h1111_AAAA_3333_AAAA);
        idle_inputs();
        step();
        check("idle_en", reg_en, 1'b0);
        check("idle_gnt", {gnt1, gnt0}, 2'b00);
        check("idle_d", reg_d, 64'h1111_AAAA_3333_AAAA);

        // Second back-to-back pair: the second write must see the first.
        req0 = 1'b1; data0 = 64'hDEAD_0000_0000_0000; mask0 = 4'b1000;
        step();
        check("b2b_a_d", reg_d, 64'hDEAD_AAAA_3333_AAAA);
        idle_inputs();
        req1 = 1'b1; data1 = 64'h0000_0000_0000_BEEF; mask1 = 4'b0001;
        step();
        check("b2b_b_d", reg_d, 64'hDEAD_AAAA_3333_BEEF);
        check("b2b_b_en", reg_en, 1'b1);

        // Zero-mask write: grant without enable.
        idle_inputs();
        req1 = 1'b1; data1 = 64'hFFFF_FFFF_FFFF_FFFF; mask1 = 4'b0000;
        step();
        check("zmask_gnt", {gnt1, gnt0}, 2'b10);
        check("zmask_en", reg_en, 1'b0);
        check("zmask_d", reg_d, 64'hDEAD_AAAA_3333_BEEF);

        // Round-robin with both held (last served was requester 1).
        idle_inputs();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr%0d_gnt", i), {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle_inputs();
        step();
        check("rr_end_gnt", {gnt1, gnt0}, 2'b00);

        // Lock and timeout.
        req0 = 1'b1; lock0 = 1'b1;
        step();
        check("lk_gnt", {gnt1, gnt0}, 2'b01);
        check("lk_owner", owner, 2'b01);
        req0 = 1'b0; req1 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("lk_wait%0d", k), {gnt1, gnt0, owner, lock_to}, 5'b00_01_0);
        end
        step();
        check("lk_to_pulse", lock_to, 1'b1);
        check("lk_to_gnt1", {gnt1, gnt0}, 2'b10);
        check("lk_to_owner", owner, 2'b00);
        idle_inputs();
        step();
        check("lk_to_clear", {lock_to, gnt1, gnt0}, 3'b000);

        // Explicit unlock: owner wins with lock low, pending req1 waits.
        req0 = 1'b1; lock0 = 1'b1;
        step();
        check("ul_owner", owner, 2'b01);
        lock0 = 1'b0; req1 = 1'b1;
        step();
        check("ul_gnt", {gnt1, gnt0}, 2'b01);
        check("ul_owner0", owner, 2'b00);
        req0 = 1'b0;
        step();
        check("ul_gnt1", {gnt1, gnt0}, 2'b10);

        // Reset mid-operation while requester 1 owns and writes.
        idle_inputs();
        req1 = 1'b1; lock1 = 1'b1; data1 = 64'h0000_0000_0000_1234; mask1 = 4'b0001;
        step();
        check("mr_pre", {reg_en, gnt1, owner}, 4'b1_1_10);
        rst = 1'b0;
        #1;
        check("mr_async", {reg_en, gnt1, gnt0, owner, lock_to}, 6'b0);
        check("mr_async_d", reg_d, 64'h0);
        idle_inputs();
        #1;
        rst = 1'b1;
        req0 = 1'b1; data0 = 64'h0000_0000_0000_FFFF; mask0 = 4'b0001;
        step();
        check("mr_post_d", reg_d, 64'h0000_0000_0000_FFFF);
        check("mr_post_gnt", {reg_en, gnt1, gnt0}, 3'b101);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
